vga_vram_arbiter: RTL and testbench

Shares one single-port video RAM (VRAM) between the CPU bus and the VGA scanout path. It prefetches pixels in raster order into a small FIFO that feeds `vga_driver`'s pixel inputs, and grants leftover memory cycles to CPU reads and writes. It sits between the memory-mapped video peripheral interface, the VRAM macro and `vga_driver`. Pixels are RGB332, one byte per pixel; the frame is 640x480.

---
 rtl/vga_vram_arbiter.sv | 166 ++++++++++++++++
 tb/tb_vga_vram_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: raster-order scanout prefetch into a small pixel FIFO,
// leftover cycles granted to CPU reads/writes. Scan wins when the FIFO runs low.
module vga_vram_arbiter #(
  parameter int VRAM_ADDR_WIDTH = 19,
  parameter int FRAME_PIXELS    = 307200,
  parameter int FIFO_DEPTH      = 16,
  parameter int LOW_WATERMARK   = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic                       video_active,
  output logic [7:0]                 pixel_data,
  output logic                       pixel_underflow,
  input  logic                       cpu_request,
  input  logic                       cpu_write_enable,
  input  logic [VRAM_ADDR_WIDTH-1:0] cpu_address,
  input  logic [7:0]                 cpu_write_data,
  output logic [7:0]                 cpu_read_data,
  output logic                       cpu_ready,
  output logic [VRAM_ADDR_WIDTH-1:0] vram_address,
  output logic                       vram_write_enable,
  output logic [7:0]                 vram_write_data,
  input  logic [7:0]                 vram_read_data
);
  localparam int AW = VRAM_ADDR_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int OW = LW + 1;
  localparam logic [OW-1:0] DEPTH_C = OW'(FIFO_DEPTH);
  localparam logic [OW-1:0] WM_C    = OW'(LOW_WATERMARK);
  localparam logic [AW-1:0] LAST_C  = AW'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {CPU_IDLE, CPU_ISSUED, CPU_DONE} cpu_state_e;
  typedef enum logic {TAG_SCAN = 1'b0, TAG_CPU = 1'b1} tag_e;

  cpu_state_e        cpu_state_q, cpu_state_d;
  logic              cpu_wr_q, cpu_wr_d;
  logic [7:0]        cpu_read_data_q, cpu_read_data_d;
  logic              ret_vld_q, ret_vld_d;
  tag_e              ret_tag_q, ret_tag_d;
  logic [AW-1:0]     fetch_addr_q, fetch_addr_d;
  logic              fetch_done_q, fetch_done_d;
  logic [LW-1:0]     level_q, level_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [7:0]        mem_d [FIFO_DEPTH];
  logic              underflow_q, underflow_d;

  logic          inflight, scan_elig, scan_urgent, cpu_can, grant_scan, grant_cpu;
  logic          push, pop;
  logic [OW-1:0] occ;

  // Scan grants are held off during frame_start so no stale tag can outlive the flush.
  always_comb begin
    inflight    = ret_vld_q && (ret_tag_q == TAG_SCAN);
    occ         = OW'(level_q) + OW'(inflight);
    scan_elig   = !fetch_done_q && !frame_start && (occ < DEPTH_C);
    scan_urgent = scan_elig && (occ < WM_C);
    cpu_can     = !reset && (cpu_state_q == CPU_IDLE) && cpu_request;
    grant_scan  = scan_urgent || (scan_elig && !cpu_can);
    grant_cpu   = cpu_can && !scan_urgent;
  end

  always_comb begin
    vram_address      = '0;
    vram_write_enable = 1'b0;
    vram_write_data   = 8'h00;
    if (grant_cpu) begin
      vram_address      = cpu_address;
      vram_write_enable = cpu_write_enable;
      vram_write_data   = cpu_write_enable ? cpu_write_data : 8'h00;
    end else if (grant_scan) begin
      vram_address = fetch_addr_q;
    end
  end

  always_comb begin
    ret_vld_d = grant_scan || (grant_cpu && !cpu_write_enable);
    ret_tag_d = grant_cpu ? TAG_CPU : TAG_SCAN;
    fetch_addr_d = fetch_addr_q;
    fetch_done_d = fetch_done_q;
    if (frame_start) begin
      fetch_addr_d = '0;
      fetch_done_d = 1'b0;
    end else if (grant_scan) begin
      fetch_addr_d = fetch_addr_q + 1'b1;
      if (fetch_addr_q == LAST_C) fetch_done_d = 1'b1;
    end
  end

  // Pixel FIFO; frame_start wins over any same-cycle push or pop.
  always_comb begin
    push        = inflight && !frame_start;
    pop         = video_active && (level_q != '0) && !frame_start;
    mem_d       = mem_q;
    level_d     = level_q + LW'(push) - LW'(pop);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    wr_ptr_d    = wr_ptr_q + PW'(push);
    underflow_d = underflow_q || (video_active && (level_q == '0));
    if (push) mem_d[wr_ptr_q] = vram_read_data;
    if (frame_start) begin
      level_d     = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      underflow_d = 1'b0;
    end
  end

  always_comb begin
    cpu_state_d     = cpu_state_q;
    cpu_wr_d        = cpu_wr_q;
    cpu_ready       = 1'b0;
    cpu_read_data_d = cpu_read_data_q;
    if (ret_vld_q && (ret_tag_q == TAG_CPU)) cpu_read_data_d = vram_read_data;
    case (cpu_state_q)
      CPU_IDLE: if (grant_cpu) begin
        cpu_state_d = CPU_ISSUED;
        cpu_wr_d    = cpu_write_enable;
      end
      CPU_ISSUED: begin
        cpu_ready   = cpu_wr_q;
        cpu_state_d = cpu_wr_q ? CPU_IDLE : CPU_DONE;
      end
      CPU_DONE: begin
        cpu_ready   = 1'b1;
        cpu_state_d = CPU_IDLE;
      end
      default: cpu_state_d = CPU_IDLE;
    endcase
  end

  assign pixel_data      = (level_q == '0) ? 8'h00 : mem_q[rd_ptr_q];
  assign pixel_underflow = underflow_q;
  assign cpu_read_data   = cpu_read_data_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_state_q     <= CPU_IDLE;
      cpu_wr_q        <= 1'b0;
      cpu_read_data_q <= 8'h00;
      ret_vld_q       <= 1'b0;
      ret_tag_q       <= TAG_SCAN;
      fetch_addr_q    <= '0;
      fetch_done_q    <= 1'b1;
      level_q         <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      underflow_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      cpu_state_q     <= cpu_state_d;
      cpu_wr_q        <= cpu_wr_d;
      cpu_read_data_q <= cpu_read_data_d;
      ret_vld_q       <= ret_vld_d;
      ret_tag_q       <= ret_tag_d;
      fetch_addr_q    <= fetch_addr_d;
      fetch_done_q    <= fetch_done_d;
      level_q         <= level_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      underflow_q     <= underflow_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end
endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter: a cycle table for prefill and CPU access,
// then hand-written sequences for underflow, mid-fetch frame_start, watermark, streaming, reset.
`timescale 1ns/1ps
module tb_vga_vram_arbiter;
  localparam int AW = 19;

  logic          clock = 1'b0;
  logic          reset;
  logic          frame_start, video_active;
  logic [7:0]    pixel_data;
  logic          pixel_underflow;
  logic          cpu_request, cpu_write_enable;
  logic [AW-1:0] cpu_address;
  logic [7:0]    cpu_write_data, cpu_read_data;
  logic          cpu_ready;
  logic [AW-1:0] vram_address;
  logic          vram_write_enable;
  logic [7:0]    vram_write_data;
  logic [7:0]    vram_read_data = 8'h00;

  int checks = 0;
  int errors = 0;

  vga_vram_arbiter dut (
    .clock(clock), .reset(reset), .frame_start(frame_start), .video_active(video_active),
    .pixel_data(pixel_data), .pixel_underflow(pixel_underflow),
    .cpu_request(cpu_request), .cpu_write_enable(cpu_write_enable),
    .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
    .cpu_read_data(cpu_read_data), .cpu_ready(cpu_ready),
    .vram_address(vram_address), .vram_write_enable(vram_write_enable),
    .vram_write_data(vram_write_data), .vram_read_data(vram_read_data)
  );

  always #5 clock = ~clock;

  // VRAM model: VRAM[i] = i[7:0] initially, one-cycle read latency.
  logic [7:0] vmem [0:65535];
  initial for (int i = 0; i < 65536; i++) vmem[i] <= 8'(i);
  always @(posedge clock) begin
    if (vram_write_enable) vmem[vram_address[15:0]] <= vram_write_data;
    vram_read_data <= vmem[vram_address[15:0]];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic fs, va, req, we;
    logic [AW-1:0] a;
    logic [7:0] wd;
    logic [AW-1:0] ea;
    logic ewe;
    logic [7:0] ewd;
    logic erdy, crd;
    logic [7:0] erd, epix;
    logic euf;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic fs, va, req, we, input logic [AW-1:0] a, input logic [7:0] wd,
                     input logic [AW-1:0] ea, input logic ewe, input logic [7:0] ewd,
                     input logic erdy, crd, input logic [7:0] erd, epix, input logic euf);
    vec_t v;
    v = '{fs, va, req, we, a, wd, ea, ewe, ewd, erdy, crd, erd, epix, euf};
    tbl.push_back(v);
  endtask

  task automatic cpu_xfer(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                          output logic [7:0] rd);
    logic ok;
    ok = 1'b0;
    rd = 8'h00;
    @(negedge clock);
    cpu_request = 1'b1; cpu_write_enable = we; cpu_address = a; cpu_write_data = d;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (cpu_ready) begin ok = 1'b1; rd = cpu_read_data; break; end
      @(negedge clock);
    end
    @(negedge clock);
    cpu_request = 1'b0;
    chk("cpu_xfer completes", 32'(ok), 32'd1);
  endtask

  initial begin
    logic [7:0] rd;
    logic wr_done;
    reset = 1'b1; frame_start = 0; video_active = 0;
    cpu_request = 1; cpu_write_enable = 1; cpu_address = 19'h123; cpu_write_data = 8'h55;

    // Reset state, with a CPU write request held during reset.
    #2;
    chk("reset vram_write_enable", 32'(vram_write_enable), 0);
    chk("reset vram_address", 32'(vram_address), 0);
    chk("reset vram_write_data", 32'(vram_write_data), 0);
    chk("reset cpu_ready", 32'(cpu_ready), 0);
    chk("reset cpu_read_data", 32'(cpu_read_data), 0);
    chk("reset pixel_data", 32'(pixel_data), 0);
    chk("reset pixel_underflow", 32'(pixel_underflow), 0);
    @(negedge clock); cpu_request = 0; cpu_write_enable = 0;
    @(negedge clock); reset = 1'b0;
    repeat (3) @(negedge clock);
    video_active = 1;                  // nothing fetched before first frame_start
    @(negedge clock); video_active = 0;
    #1 chk("no fetch before frame_start", 32'(pixel_underflow), 1);

    // Cycle table: prefill, CPU write/read with FIFO full, pops with refill.
    add(1,0,0,0, 0,0, 0,0,0, 0,0,0, 0,1);
    for (int i = 1; i <= 16; i++) add(0,0,0,0, 0,0, 19'(i-1),0,0, 0,0,0, 0,0);
    repeat (4) add(0,0,0,0, 0,0, 0,0,0, 0,0,0, 0,0);
    add(0,0,1,1, 19'h100,8'hA5, 19'h100,1,8'hA5, 0,0,0, 0,0);
    add(0,0,1,1, 19'h100,8'hA5, 0,0,0, 1,0,0, 0,0);
    add(0,0,0,0, 0,0, 0,0,0, 0,0,0, 0,0);
    add(0,0,1,0, 19'h100,0, 19'h100,0,0, 0,0,0, 0,0);
    add(0,0,1,0, 19'h100,0, 0,0,0, 0,0,0, 0,0);
    add(0,0,1,0, 19'h100,0, 0,0,0, 1,1,8'hA5, 0,0);
    add(0,0,0,0, 0,0, 0,0,0, 0,0,0, 0,0);
    add(0,1,0,0, 0,0, 0,0,0, 0,0,0, 0,0);
    add(0,1,0,0, 0,0, 19'd16,0,0, 0,0,0, 1,0);
    add(0,1,0,0, 0,0, 19'd17,0,0, 0,0,0, 2,0);
    add(0,1,0,0, 0,0, 19'd18,0,0, 0,0,0, 3,0);
    add(0,0,0,0, 0,0, 19'd19,0,0, 0,0,0, 4,0);
    add(0,0,0,0, 0,0, 0,0,0, 0,0,0, 4,0);

    foreach (tbl[i]) begin
      @(negedge clock);
      frame_start = tbl[i].fs; video_active = tbl[i].va;
      cpu_request = tbl[i].req; cpu_write_enable = tbl[i].we;
      cpu_address = tbl[i].a; cpu_write_data = tbl[i].wd;
      #1;
      chk($sformatf("row%0d vram_address", i), 32'(vram_address), 32'(tbl[i].ea));
      chk($sformatf("row%0d vram_write_enable", i), 32'(vram_write_enable), 32'(tbl[i].ewe));
      if (tbl[i].ewe) chk($sformatf("row%0d vram_write_data", i), 32'(vram_write_data), 32'(tbl[i].ewd));
      chk($sformatf("row%0d cpu_ready", i), 32'(cpu_ready), 32'(tbl[i].erdy));
      if (tbl[i].crd) chk($sformatf("row%0d cpu_read_data", i), 32'(cpu_read_data), 32'(tbl[i].erd));
      chk($sformatf("row%0d pixel_data", i), 32'(pixel_data), 32'(tbl[i].epix));
      chk($sformatf("row%0d pixel_underflow", i), 32'(pixel_underflow), 32'(tbl[i].euf));
    end

    // Underflow right after frame_start, sticky until the next one.
    @(negedge clock); frame_start = 1; video_active = 0; cpu_request = 0;
    @(negedge clock); frame_start = 0; video_active = 1;
    #1 chk("underflow pop pixel_data", 32'(pixel_data), 0);
    @(negedge clock); video_active = 0;
    #1 chk("underflow set", 32'(pixel_underflow), 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock); video_active = 1;
      #1 chk($sformatf("prefill pop %0d", k), 32'(pixel_data), 32'(k));
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clock); video_active = 0;
      #1 chk("underflow sticky", 32'(pixel_underflow), 1);
    end
    // frame_start with scan read of address 5 in flight and 2,3,4 still queued.
    @(negedge clock); frame_start = 1;
    #1 chk("underflow held in frame_start cycle", 32'(pixel_underflow), 1);
    @(negedge clock); frame_start = 0;
    #1 chk("restart underflow cleared", 32'(pixel_underflow), 0);
    chk("restart fetch addr 0", 32'(vram_address), 0);
    chk("restart fifo empty", 32'(pixel_data), 0);
    @(negedge clock);
    #1 chk("restart fetch addr 1", 32'(vram_address), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock); video_active = 1;
      #1 chk($sformatf("restart pop %0d", k), 32'(pixel_data), 32'(k));
    end
    @(negedge clock); video_active = 0;
    #1 chk("restart no underflow", 32'(pixel_underflow), 0);

    // Watermark: pending CPU read waits until level+inflight reaches 8.
    @(negedge clock); frame_start = 1;
    @(negedge clock); frame_start = 0;
    cpu_request = 1; cpu_write_enable = 0; cpu_address = 19'h100;
    for (int k = 0; k < 8; k++) begin
      #1 chk($sformatf("urgent scan addr %0d", k), 32'(vram_address), 32'(k));
      @(negedge clock);
    end
    #1 chk("cpu granted at watermark", 32'(vram_address), 32'h100);
    chk("cpu read no strobe", 32'(vram_write_enable), 0);
    @(negedge clock);
    #1 chk("scan resumes addr 8", 32'(vram_address), 8);
    chk("read not ready at G+1", 32'(cpu_ready), 0);
    @(negedge clock);
    #1 chk("read ready at G+2", 32'(cpu_ready), 1);
    chk("read data", 32'(cpu_read_data), 32'hA5);
    @(negedge clock); cpu_request = 0;

    // Stream 640 pixels; one CPU write slips in while the FIFO is above the watermark.
    @(negedge clock); frame_start = 1;
    @(negedge clock); frame_start = 0;
    repeat (19) @(negedge clock);
    cpu_xfer(1'b1, 19'h100, 8'h00, rd);
    wr_done = 1'b0;
    for (int k = 0; k < 640; k++) begin
      @(negedge clock); video_active = 1;
      if (k == 100) begin
        cpu_request = 1; cpu_write_enable = 1; cpu_address = 19'h3000; cpu_write_data = 8'h77;
      end
      if (wr_done) cpu_request = 0;
      #1 chk($sformatf("stream pixel %0d", k), 32'(pixel_data), 32'(k[7:0]));
      if (cpu_request && cpu_ready) wr_done = 1'b1;
    end
    @(negedge clock); video_active = 0; cpu_request = 0;
    #1 chk("stream no underflow", 32'(pixel_underflow), 0);
    chk("stream cpu write done", 32'(wr_done), 1);
    cpu_xfer(1'b0, 19'h3000, 8'h00, rd);
    chk("readback 0x3000", 32'(rd), 32'h77);

    // Reset in the grant cycle of a write: strobe drops at once, no ready later.
    @(negedge clock);
    cpu_request = 1; cpu_write_enable = 1; cpu_address = 19'h205; cpu_write_data = 8'h33;
    #1 chk("pre-reset write strobe", 32'(vram_write_enable), 1);
    #1 reset = 1'b1;
    #1 chk("reset drops write strobe", 32'(vram_write_enable), 0);
    @(negedge clock); cpu_request = 0;
    @(negedge clock); reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("no ready after reset", 32'(cpu_ready), 0);
      @(negedge clock);
    end
    chk("aborted write not stored", 32'(vmem[16'h205]), 32'h05);
    chk("post-reset cpu_read_data", 32'(cpu_read_data), 0);
    chk("post-reset pixel_data", 32'(pixel_data), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
